// File: rtl/reg_load_seq.sv
// reg_load_seq: sequences register-transfer requests into one-cycle load ops
// on the A/X/Y/S register op inputs, then issues a one-cycle flag strobe.
//
// Optional feature macro: REG_LOAD_SEQ_QUEUE_EN adds a one-entry request queue
// so a new request can be accepted while a transfer is in flight.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   req_valid/req_ready  request handshake
//   req_src[1:0]         source select (0=A,1=B,2=C,3=D)
//   req_dst[1:0]         destination (0=A,1=X,2=Y,3=S)
//   op_a/x/y/s[2:0]      register load ops (000 hold, 001..100 load src)
//   flag_we              N/Z flag update strobe (never for dst S)
//   done                 one-cycle pulse at end of each transfer
//   busy                 high when not idle
module reg_load_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dst,
  output logic [2:0] op_a,
  output logic [2:0] op_x,
  output logic [2:0] op_y,
  output logic [2:0] op_s,
  output logic       flag_we,
  output logic       done,
  output logic       busy
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
  localparam logic [ST_W-1:0] ST_FLAG = 2'd2;

  localparam logic [SEL_W-1:0] DST_A = 2'd0;
  localparam logic [SEL_W-1:0] DST_X = 2'd1;
  localparam logic [SEL_W-1:0] DST_Y = 2'd2;
  localparam logic [SEL_W-1:0] DST_S = 2'd3;

  logic [ST_W-1:0]  state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] dst_q, dst_d;
  logic [OP_W-1:0]  op_a_q, op_a_d, op_x_q, op_x_d;
  logic [OP_W-1:0]  op_y_q, op_y_d, op_s_q, op_s_d;
  logic [OP_W-1:0]  load_code;
  logic             flag_we_q, flag_we_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             hs;

`ifdef REG_LOAD_SEQ_QUEUE_EN
  logic             qv_q, qv_d;
  logic [SEL_W-1:0] q_src_q, q_src_d;
  logic [SEL_W-1:0] q_dst_q, q_dst_d;
`endif

  assign hs = req_valid && ready_q;

  // State and registered outputs; reset clears op outputs without a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      op_a_q    <= '0;
      op_x_q    <= '0;
      op_y_q    <= '0;
      op_s_q    <= '0;
      flag_we_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef REG_LOAD_SEQ_QUEUE_EN
      qv_q      <= 1'b0;
      q_src_q   <= '0;
      q_dst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      op_a_q    <= op_a_d;
      op_x_q    <= op_x_d;
      op_y_q    <= op_y_d;
      op_s_q    <= op_s_d;
      flag_we_q <= flag_we_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef REG_LOAD_SEQ_QUEUE_EN
      qv_q      <= qv_d;
      q_src_q   <= q_src_d;
      q_dst_q   <= q_dst_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
`ifdef REG_LOAD_SEQ_QUEUE_EN
    qv_d    = qv_q;
    q_src_d = q_src_q;
    q_dst_d = q_dst_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d = ST_LOAD;
          src_d   = req_src;
          dst_d   = req_dst;
        end
      end
      ST_LOAD: begin
        state_d = ST_FLAG;
`ifdef REG_LOAD_SEQ_QUEUE_EN
        // Ready in LOAD implies the queue is empty.
        if (hs) begin
          qv_d    = 1'b1;
          q_src_d = req_src;
          q_dst_d = req_dst;
        end
`endif
      end
      ST_FLAG: begin
`ifdef REG_LOAD_SEQ_QUEUE_EN
        if (qv_q) begin
          // Drain the queue into the FSM; a same-cycle request refills the slot.
          state_d = ST_LOAD;
          src_d   = q_src_q;
          dst_d   = q_dst_q;
          qv_d    = hs;
          if (hs) begin
            q_src_d = req_src;
            q_dst_d = req_dst;
          end
        end else if (hs) begin
          // Request enters an empty queue and is drained in the same cycle.
          state_d = ST_LOAD;
          src_d   = req_src;
          dst_d   = req_dst;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    load_code = OP_W'({1'b0, src_d}) + OP_W'(1);

    op_a_d = '0;
    op_x_d = '0;
    op_y_d = '0;
    op_s_d = '0;
    if (state_d == ST_LOAD) begin
      case (dst_d)
        DST_A:   op_a_d = load_code;
        DST_X:   op_x_d = load_code;
        DST_Y:   op_y_d = load_code;
        DST_S:   op_s_d = load_code;
        default: op_a_d = '0;
      endcase
    end

    flag_we_d = (state_d == ST_FLAG) && (dst_d != DST_S);
    done_d    = (state_d == ST_FLAG);
    busy_d    = (state_d != ST_IDLE);
`ifdef REG_LOAD_SEQ_QUEUE_EN
    ready_d   = !qv_d || (state_d == ST_FLAG);
`else
    ready_d   = (state_d == ST_IDLE);
`endif
  end

  assign req_ready = ready_q;
  assign op_a      = op_a_q;
  assign op_x      = op_x_q;
  assign op_y      = op_y_q;
  assign op_s      = op_s_q;
  assign flag_we   = flag_we_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_load_seq.sv
// Scoreboard bench for reg_load_seq: expected transfers are pushed on each
// observed handshake and popped when the load op and done pulse appear.
module tb_reg_load_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src;
  logic [1:0] req_dst;
  logic [2:0] op_a, op_x, op_y, op_s;
  logic       flag_we, done, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_op = -100;
  int done_cnt = 0;
  bit chk_busy = 1'b0;

`ifdef REG_LOAD_SEQ_QUEUE_EN
  localparam int SPACE = 2;
`else
  localparam int SPACE = 3;
`endif

  typedef struct {
    int dst;
    int code;
    int flag;
    int cyc;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t done_q[$];

  reg_load_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .op_a      (op_a),
    .op_x      (op_x),
    .op_y      (op_y),
    .op_s      (op_s),
    .flag_we   (flag_we),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input integer obs, input integer exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Handshake capture: expected op cycle is the handshake edge, or later if
  // the previous transfer still occupies the minimum spacing.
  always @(posedge clk) begin
    xfer_t e;
    cyc = cyc + 1;
    if (!reset_n) begin
      last_op = -100;
      exp_q.delete();
      done_q.delete();
    end else if (req_valid && req_ready) begin
      e.dst  = int'(req_dst);
      e.code = int'(req_src) + 1;
      e.flag = (req_dst != 2'd3) ? 1 : 0;
      e.cyc  = (cyc > last_op + SPACE) ? cyc : last_op + SPACE;
      last_op = e.cyc;
      exp_q.push_back(e);
    end
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    xfer_t e;
    xfer_t d;
    int nz;
    if (reset_n) begin
      nz = int'(op_a != 3'd0) + int'(op_x != 3'd0) + int'(op_y != 3'd0) + int'(op_s != 3'd0);
      if (chk_busy) check("busy_b2b", 32'(busy), 1);
      if (nz != 0) begin
        check("op_onehot", nz, 1);
        if (exp_q.size() == 0) begin
          check("op_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("op_a", 32'(op_a), (e.dst == 0) ? e.code : 0);
          check("op_x", 32'(op_x), (e.dst == 1) ? e.code : 0);
          check("op_y", 32'(op_y), (e.dst == 2) ? e.code : 0);
          check("op_s", 32'(op_s), (e.dst == 3) ? e.code : 0);
          check("op_cycle", cyc, e.cyc);
          d = e;
          d.cyc = cyc + 1;
          done_q.push_back(d);
        end
      end
      if (done || flag_we) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", done_q.size(), 1);
        end else begin
          d = done_q.pop_front();
          check("done", 32'(done), 1);
          check("flag_we", 32'(flag_we), d.flag);
          check("done_cycle", cyc, d.cyc);
          done_cnt++;
        end
      end
    end
  end

  // Present a request from a negedge and return at the negedge after it is taken.
  task automatic send(input logic [1:0] s, input logic [1:0] d);
    int n;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("hs_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("drain_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_src   = 2'd0;
    req_dst   = 2'd0;
    #1;
    check("rst_ops", 32'({op_a, op_x, op_y, op_s}), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'({done, flag_we}), 0);

    // Single transfer D -> A, then S destination (no flag update).
    send(2'd3, 2'd0);
    idle();
    drain();
    check("idle_ready", 32'(req_ready), 1);
    send(2'd1, 2'd3);
    idle();
    drain();

    // Fields changed after acceptance only matter at the next handshake.
    send(2'd0, 2'd2);
    send(2'd3, 2'd1);
    idle();
    drain();

    // All source/destination combinations.
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 4; d++) begin
        send(2'(s), 2'(d));
      end
    end
    idle();
    drain();

    // Back-to-back requests A->X, B->Y, C->A.
    base = done_cnt;
    send(2'd0, 2'd1);
`ifdef REG_LOAD_SEQ_QUEUE_EN
    chk_busy = 1'b1;
`endif
    send(2'd1, 2'd2);
    send(2'd2, 2'd0);
    idle();
    n = 0;
    while (done_cnt < base + 3 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_busy = 1'b0;
    check("b2b_dones", done_cnt - base, 3);
    drain();

    // Reset in the middle of LOAD drops the transfer without a done.
    send(2'd2, 2'd1);
    idle();
    check("rst_pre_opx", 32'(op_x), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_opx", 32'(op_x), 0);
    check("rst_async_ops", 32'({op_a, op_y, op_s}), 0);
    check("rst_async_ready", 32'(req_ready), 0);
    check("rst_async_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 1);
    check("rel_busy", 32'(busy), 0);
    check("rel_done", 32'(done), 0);
    repeat (5) @(negedge clk);
    check("rel_no_ops", 32'({op_a, op_x, op_y, op_s}), 0);

    check("leftover", exp_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
